ft245_sync_tx: RTL

//  Transmit side of the FT232H/FT2232H synchronous 245 FIFO link: host-bound data path.

---
 rtl/ft245_pkg.sv | 18 +
 rtl/ft245_tx_fifo.sv | 77 +++++++
 rtl/ft245_sync_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared constants and FSM encoding for the FT245 synchronous FIFO link
// Used by both the transmit and receive blocks of the FT chip interface.
package ft245_pkg;

    localparam int FT_BUS_W = 8;
    localparam int COUNT_W  = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ft_state_t;

    // Pointer width for a power-of-2 FIFO: index bits plus one wrap flag.
    function automatic int ft_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ft245_tx_fifo.sv
// rtl/ft245_tx_fifo.sv - synchronous byte FIFO with registered read data
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_push_data (ignored when full)
//   i_push_data    write data
//   i_pop          load the head entry into o_pop_data (ignored when empty)
//   o_pop_data     registered read data; holds until the next pop
//   o_full/o_empty status flags
//   o_level        entries held in the memory (o_pop_data not included)
module ft245_tx_fifo
    import ft245_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = FT_BUS_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [DW-1:0]           i_push_data,
    input  logic                    i_pop,
    output logic [DW-1:0]           o_pop_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ft_ptr_w(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [DW-1:0] r_pop_data;

    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    // Same index with opposite wrap flags means the writer is a full lap ahead.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Storage is not reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // A pop only reads an entry written on an earlier edge, so there is
            // no same-cycle write-to-read bypass.
            if (w_do_pop) begin
                r_pop_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_pop_data = r_pop_data;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ft245_sync_tx.sv
// rtl/ft245_sync_tx.sv - FT232H/FT2232H synchronous 245 FIFO transmit path (FPGA -> host)
// Optional feature macro: FT245_TX_SIWU_EN (send-immediate strobe after an idle drain).
// Ports:
//   clk       FT-supplied 60 MHz clock
//   rst_n     asynchronous active-low reset
//   s_data    byte from FPGA logic; taken when s_valid && s_ready at posedge
//   s_valid   s_data valid
//   s_ready   buffer can accept a byte
//   txe_n     FT TXE#, low when the FT can accept a byte
//   ft_data   byte driven onto the FT data bus
//   data_oe   this block owns the bus (equals ~wr_n)
//   wr_n      FT WR#, low while ft_data holds a byte to write
//   siwu_n    FT SIWU#, one-cycle low pulse after a drain (constant 1 without the macro)
//   level     bytes in the buffer, excluding the ft_data register
//   tx_count  bytes accepted by the FT since reset, wrapping
module ft245_sync_tx
    import ft245_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int SIWU_IDLE  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FT_BUS_W-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          txe_n,
    output logic [FT_BUS_W-1:0]           ft_data,
    output logic                          data_oe,
    output logic                          wr_n,
    output logic                          siwu_n,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [COUNT_W-1:0]            tx_count
);

    ft_state_t            r_state;
    ft_state_t            w_state_nxt;
    logic                 r_ready_en;
    logic [COUNT_W-1:0]   r_tx_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_taken;
    logic                 w_full;
    logic                 w_empty;
    logic [FT_BUS_W-1:0]  w_ft_data;

    // The FIFO's registered read port is the ft_data output register.
    ft245_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (FT_BUS_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (s_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_ft_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (level)
    );

    // s_ready stays low through reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    assign s_ready = r_ready_en && !w_full;
    assign w_push  = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In ACTIVE the byte on ft_data is taken whenever txe_n is low; the next
    // byte is popped in the same cycle so back-to-back writes run at 1 B/clk.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_taken     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!txe_n && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!txe_n) begin
                    w_taken = 1'b1;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_count <= '0;
        end else if (w_taken) begin
            r_tx_count <= r_tx_count + 1'b1;
        end
    end

    assign wr_n     = (r_state != ST_ACTIVE);
    assign data_oe  = (r_state == ST_ACTIVE);
    assign ft_data  = w_ft_data;
    assign tx_count = r_tx_count;

`ifdef FT245_TX_SIWU_EN
    localparam int IW = $clog2(SIWU_IDLE + 1);

    logic          r_siwu_armed;
    logic [IW-1:0] r_idle_cnt;
    logic          r_siwu_n;

    // Armed only by the ACTIVE->IDLE transition, which implies at least one
    // byte went out and the buffer is empty. A push always disarms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_siwu_armed <= 1'b0;
            r_idle_cnt   <= '0;
            r_siwu_n     <= 1'b1;
        end else begin
            r_siwu_n <= 1'b1;
            if (w_push) begin
                r_siwu_armed <= 1'b0;
                r_idle_cnt   <= '0;
            end else if (r_state == ST_ACTIVE && w_state_nxt == ST_IDLE) begin
                r_siwu_armed <= 1'b1;
                r_idle_cnt   <= '0;
            end else if (r_siwu_armed && r_state == ST_IDLE && w_empty) begin
                if (r_idle_cnt == IW'(SIWU_IDLE - 1)) begin
                    r_siwu_n     <= 1'b0;
                    r_siwu_armed <= 1'b0;
                    r_idle_cnt   <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
        end
    end

    assign siwu_n = r_siwu_n;
`else
    assign siwu_n = 1'b1;
`endif

endmodule
